// File: rtl/bit_ser_pkg.sv
// Shared types and helpers for the bit serializer.
// Holds the FSM state encoding and the bit-counter width function.
package bit_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bit_ser_state_t;

    // Never narrower than one bit, even for WIDTH=2.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter with valid/ready input and frame strobe.
// Reloads on the last bit so back-to-back words stream without a gap.
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    bit_ser_state_t   state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;
    logic             accept;

    assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST);
    assign din_ready = clr && ((state_q == IDLE) || last_bit);
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (state_q == SHIFT) begin
            sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
        // A load on the last bit overrides the return to IDLE.
        if (accept) begin
            sreg_d  = din;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign ser_frame = busy;
    assign ser_out   = busy &&
                       (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);

endmodule
